// File: rtl/cr16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr16_pkg
// Description : Shared CR16 definitions for the writeback stage and the branch
//               unit. It holds the PSR layout, the status bit indices and the
//               4-bit branch condition-code encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cr16_pkg;

    // Width of the Processor Status Register. It is also the width of the ALU
    // status vector.
    localparam int c_psr_w = 5;

    // Bit positions in the PSR and in the ALU status vector.
    localparam int c_stat_c = 0;  // carry
    localparam int c_stat_l = 1;  // low (unsigned compare)
    localparam int c_stat_f = 2;  // flag (overflow)
    localparam int c_stat_z = 3;  // zero
    localparam int c_stat_n = 4;  // negative (signed compare)

    // Branch condition codes.
    localparam logic [3:0] c_cond_eq    = 4'd0;
    localparam logic [3:0] c_cond_ne    = 4'd1;
    localparam logic [3:0] c_cond_cs    = 4'd2;
    localparam logic [3:0] c_cond_cc    = 4'd3;
    localparam logic [3:0] c_cond_hi    = 4'd4;
    localparam logic [3:0] c_cond_ls    = 4'd5;
    localparam logic [3:0] c_cond_gt    = 4'd6;
    localparam logic [3:0] c_cond_le    = 4'd7;
    localparam logic [3:0] c_cond_fs    = 4'd8;
    localparam logic [3:0] c_cond_fc    = 4'd9;
    localparam logic [3:0] c_cond_lo    = 4'd10;
    localparam logic [3:0] c_cond_hs    = 4'd11;
    localparam logic [3:0] c_cond_lt    = 4'd12;
    localparam logic [3:0] c_cond_ge    = 4'd13;
    localparam logic [3:0] c_cond_uc    = 4'd14;
    localparam logic [3:0] c_cond_never = 4'd15;

endpackage : cr16_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational CR16 branch condition evaluator. It
//               decodes a 4-bit condition code against a PSR value. The
//               branch unit uses this block as well.
// Ports       : i_psr  [c_psr_w-1:0] - flags {N,Z,F,L,C}
//               i_cond [3:0]         - condition code
//               o_true               - condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import cr16_pkg::*;
(
    input  logic [c_psr_w-1:0] i_psr,
    input  logic [3:0]         i_cond,
    output logic               o_true
);

    logic w_c;
    logic w_l;
    logic w_f;
    logic w_z;
    logic w_n;

    assign w_c = i_psr[c_stat_c];
    assign w_l = i_psr[c_stat_l];
    assign w_f = i_psr[c_stat_f];
    assign w_z = i_psr[c_stat_z];
    assign w_n = i_psr[c_stat_n];

    always_comb begin
        o_true = 1'b0;
        case (i_cond)
            c_cond_eq:    o_true = w_z;
            c_cond_ne:    o_true = ~w_z;
            c_cond_cs:    o_true = w_c;
            c_cond_cc:    o_true = ~w_c;
            c_cond_hi:    o_true = w_l;
            c_cond_ls:    o_true = ~w_l;
            c_cond_gt:    o_true = w_n;
            c_cond_le:    o_true = ~w_n;
            c_cond_fs:    o_true = w_f;
            c_cond_fc:    o_true = ~w_f;
            c_cond_lo:    o_true = ~w_l & ~w_z;
            c_cond_hs:    o_true = w_l | w_z;
            c_cond_lt:    o_true = ~w_n & ~w_z;
            c_cond_ge:    o_true = w_n | w_z;
            c_cond_uc:    o_true = 1'b1;
            c_cond_never: o_true = 1'b0;
            default:      o_true = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_stage
// Description : CR16 writeback/status stage that sits after the ALU. It takes
//               ALU results through a valid/ready handshake and holds them in
//               a two-entry skid buffer. The buffer head drives the
//               register-file write port. The stage also owns the
//               architectural PSR and evaluates branch conditions against it.
// Config      : ALU_WB_PSR_BYPASS_EN - when defined, o_cond_true sees the
//               incoming status in the same cycle as a flag-setting accept,
//               so a compare can be followed by a branch with no bubble.
// Ports       : i_clk, i_nreset (async, active low)
//               upstream  : i_valid/o_ready, i_c, i_status, i_wb_en,
//                           i_wb_addr, i_flags_en, i_flush
//               downstream: o_valid/i_ready, o_data, o_wb_en, o_wb_addr
//               status    : o_psr, i_cond -> o_cond_true
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage
    import cr16_pkg::*;
#(
    parameter int P_WIDTH      = 16,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_nreset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [P_WIDTH-1:0]      i_c,
    input  logic [c_psr_w-1:0]      i_status,
    input  logic                    i_wb_en,
    input  logic [P_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic                    i_flags_en,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [P_WIDTH-1:0]      o_data,
    output logic                    o_wb_en,
    output logic [P_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [c_psr_w-1:0]      o_psr,
    input  logic [3:0]              i_cond,
    output logic                    o_cond_true
);

    // Buffer occupancy doubles as the state encoding.
    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    logic [1:0]              r_count;
    logic [P_WIDTH-1:0]      r_head_data;
    logic                    r_head_wb_en;
    logic [P_ADDR_WIDTH-1:0] r_head_addr;
    logic [P_WIDTH-1:0]      r_tail_data;
    logic                    r_tail_wb_en;
    logic [P_ADDR_WIDTH-1:0] r_tail_addr;
    logic [c_psr_w-1:0]      r_psr;

    logic                    w_accept;
    logic                    w_pop;
    logic                    w_take;
    logic                    w_flag_wr;
    logic [c_psr_w-1:0]      w_cond_psr;

    // Ready and valid decode only registered occupancy. This keeps
    // i_valid/i_ready from reaching them combinationally.
    assign o_ready   = (r_count != c_full);
    assign o_valid   = (r_count != c_empty);
    assign o_data    = r_head_data;
    assign o_wb_en   = r_head_wb_en & o_valid;
    assign o_wb_addr = r_head_addr;
    assign o_psr     = r_psr;

    assign w_accept  = i_valid & o_ready;
    assign w_pop     = o_valid & i_ready;
    // A flush kills a coincident accept. That covers both its data and its
    // flags.
    assign w_take    = w_accept & ~i_flush;
    assign w_flag_wr = w_take & i_flags_en;

    // ------------------------------------------------------------------
    // Two-entry skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_count      <= c_empty;
            r_head_data  <= '0;
            r_head_wb_en <= 1'b0;
            r_head_addr  <= '0;
            r_tail_data  <= '0;
            r_tail_wb_en <= 1'b0;
            r_tail_addr  <= '0;
        end else if (i_flush) begin
            r_count <= c_empty;
        end else begin
            case (r_count)
                c_empty: begin
                    if (w_take) begin
                        r_head_data  <= i_c;
                        r_head_wb_en <= i_wb_en;
                        r_head_addr  <= i_wb_addr;
                        r_count      <= c_one;
                    end
                end
                c_one: begin
                    if (w_take && w_pop) begin
                        // Head drains and the new entry replaces it.
                        r_head_data  <= i_c;
                        r_head_wb_en <= i_wb_en;
                        r_head_addr  <= i_wb_addr;
                    end else if (w_take) begin
                        r_tail_data  <= i_c;
                        r_tail_wb_en <= i_wb_en;
                        r_tail_addr  <= i_wb_addr;
                        r_count      <= c_full;
                    end else if (w_pop) begin
                        r_count <= c_empty;
                    end
                end
                c_full: begin
                    // o_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_head_data  <= r_tail_data;
                        r_head_wb_en <= r_tail_wb_en;
                        r_head_addr  <= r_tail_addr;
                        r_count      <= c_one;
                    end
                end
                default: begin
                    r_count <= c_empty;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PSR. Updated at accept time, independent of when the entry drains.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_psr <= '0;
        end else if (w_flag_wr) begin
            r_psr <= i_status;
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
`ifdef ALU_WB_PSR_BYPASS_EN
    assign w_cond_psr = w_flag_wr ? i_status : r_psr;
`else
    assign w_cond_psr = r_psr;
`endif

    cond_eval u_cond_eval (
        .i_psr  (w_cond_psr),
        .i_cond (i_cond),
        .o_true (o_cond_true)
    );

endmodule : alu_wb_stage
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wb_stage
// Description : Self-checking bench for alu_wb_stage. The driver updates a
//               queue/PSR reference model at each rising edge. A monitor on
//               the falling edge compares the DUT outputs against that model.
//               When the register file consumes an entry, the monitor pops it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;

    typedef struct {
        logic [15:0] data;
        logic        wb_en;
        logic [3:0]  addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_c = '0;
    logic [4:0]  i_status = '0;
    logic        i_wb_en = 1'b0;
    logic [3:0]  i_wb_addr = '0;
    logic        i_flags_en = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_data;
    logic        o_wb_en;
    logic [3:0]  o_wb_addr;
    logic [4:0]  o_psr;
    logic [3:0]  i_cond = '0;
    logic        o_cond_true;

    ent_t        q[$];
    logic [4:0]  m_psr = '0;
    logic        m_ready = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.P_WIDTH(16), .P_ADDR_WIDTH(4)) dut (
        .i_clk       (clk),
        .i_nreset    (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_c         (i_c),
        .i_status    (i_status),
        .i_wb_en     (i_wb_en),
        .i_wb_addr   (i_wb_addr),
        .i_flags_en  (i_flags_en),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_wb_en     (o_wb_en),
        .o_wb_addr   (o_wb_addr),
        .o_psr       (o_psr),
        .i_cond      (i_cond),
        .o_cond_true (o_cond_true)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Condition table written straight from the named flag meanings.
    function automatic logic cond_model(input logic [4:0] p, input logic [3:0] cc);
        logic c, l, f, z, n;
        c = p[0]; l = p[1]; f = p[2]; z = p[3]; n = p[4];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return f;
            4'd9:  return !f;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: compare the visible state and consume the head on a pop.
    always @(negedge clk) begin
        logic [4:0] eff;
        ent_t       h;
        if (rst_n) begin
            chk("ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
            chk("valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
            chk("psr", {27'd0, o_psr}, {27'd0, m_psr});
            eff = m_psr;
`ifdef ALU_WB_PSR_BYPASS_EN
            if (i_valid && m_ready && i_flags_en && !i_flush) eff = i_status;
`endif
            chk("cond", {31'd0, o_cond_true}, {31'd0, cond_model(eff, i_cond)});
            if (q.size() > 0) begin
                h = q[0];
                chk("data", {16'd0, o_data}, {16'd0, h.data});
                chk("wb_en", {31'd0, o_wb_en}, {31'd0, h.wb_en});
                chk("wb_addr", {28'd0, o_wb_addr}, {28'd0, h.addr});
                if (i_ready) q.pop_front();
            end else begin
                chk("wb_en_idle", {31'd0, o_wb_en}, 32'd0);
            end
        end
    end

    // Advance one clock edge and apply the reference-model rules for it.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (i_flush) begin
            q.delete();
        end else if (i_valid && m_ready) begin
            e.data  = i_c;
            e.wb_en = i_wb_en;
            e.addr  = i_wb_addr;
            q.push_back(e);
            if (i_flags_en) m_psr = i_status;
        end
        #1;
        m_ready = (q.size() < 2);
    endtask

    task automatic idle();
        i_valid = 1'b0; i_flags_en = 1'b0; i_flush = 1'b0;
    endtask

    task automatic put(input logic [15:0] d, input logic [3:0] a, input logic fen, input logic [4:0] st);
        i_valid = 1'b1; i_c = d; i_wb_en = 1'b1; i_wb_addr = a;
        i_flags_en = fen; i_status = st;
    endtask

    initial begin
        logic took;
        // Reset
        #3;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_psr", {27'd0, o_psr}, 32'd0);
        #9 rst_n = 1'b1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_data", {16'd0, o_data}, 32'd0);
        chk("rst_wb_en", {31'd0, o_wb_en}, 32'd0);
        chk("rst_wb_addr", {28'd0, o_wb_addr}, 32'd0);
        @(posedge clk); #1;

        // Single accept, then pop
        put(16'h1234, 4'd3, 1'b0, 5'd0); i_ready = 1'b0;
        tick();
        idle(); i_ready = 1'b1;
        tick(); tick();

        // Back-pressure: third result waits upstream, order preserved
        i_ready = 1'b0;
        put(16'h0001, 4'd1, 1'b0, 5'd0); tick();
        put(16'h0002, 4'd2, 1'b0, 5'd0); tick();
        put(16'h0003, 4'd3, 1'b0, 5'd0); tick(); tick();
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            took = m_ready;
            tick();
            if (took) idle();
        end

        // Flag update and EQ/NE
        put(16'h00aa, 4'd5, 1'b1, 5'b01000); i_cond = 4'd0; tick();
        idle(); i_cond = 4'd0; tick();
        i_cond = 4'd1; tick();

        // Accept without flag enable; UC/never
        put(16'h00bb, 4'd6, 1'b0, 5'b11111); i_cond = 4'd14; tick();
        idle(); i_cond = 4'd15; tick(); tick();

        // Fill the buffer, then flush with a flag-setting valid
        i_ready = 1'b0;
        put(16'h0011, 4'd1, 1'b0, 5'd0); tick();
        put(16'h0022, 4'd2, 1'b0, 5'd0); tick();
        put(16'hdead, 4'd7, 1'b1, 5'b00001); i_flush = 1'b1; i_cond = 4'd2; tick();
        idle(); i_ready = 1'b1; tick(); tick();

        // Flush while one entry is held, with an accept that is otherwise legal
        i_ready = 1'b0;
        put(16'h0033, 4'd3, 1'b0, 5'd0); tick();
        put(16'hbeef, 4'd4, 1'b1, 5'b10000); i_flush = 1'b1; tick();
        idle(); i_ready = 1'b1; tick(); tick();

        // Asynchronous reset mid-cycle while full
        i_ready = 1'b0;
        put(16'h0044, 4'd4, 1'b1, 5'b00110); tick();
        put(16'h0055, 4'd5, 1'b0, 5'd0); tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, o_valid}, 32'd0);
        chk("async_psr", {27'd0, o_psr}, 32'd0);
        q.delete(); m_psr = '0; m_ready = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            if (!i_valid || m_ready) begin
                i_valid   = ($urandom_range(0, 99) < 60);
                i_c       = 16'($urandom);
                i_wb_en   = 1'($urandom);
                i_wb_addr = 4'($urandom);
                i_status  = 5'($urandom);
                i_flags_en = 1'($urandom);
            end
            i_flush = ($urandom_range(0, 99) < 5);
            i_ready = ($urandom_range(0, 99) < 50);
            i_cond  = 4'($urandom);
            tick();
        end
        idle(); i_ready = 1'b1;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_wb_stage
`default_nettype wire

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback/status stage directly downstream of the CR16 ALU.
- Captures ALU result (C) and status flags through a valid/ready handshake, buffers up to two results in a skid buffer, and presents them to the register-file write port.
- Owns the architectural Processor Status Register (PSR) and evaluates CR16 branch condition codes against it.

Parameters:
- P_WIDTH, 16, width of result data path.
- P_ADDR_WIDTH, 4, register-file address width.

Ports:
- I_CLK  input  1  clock; all state updates on rising edge.
- I_NRESET  input  1  asynchronous active-low reset.
- I_VALID  input  1  upstream ALU result valid.
- O_READY  output  1  stage can accept; equals (buffer count < 2).
- I_C  input  P_WIDTH  ALU result.
- I_STATUS  input  5  ALU status. Bits: [0] C, [1] L, [2] F, [3] Z, [4] N.
- I_WB_EN  input  1  result is to be written to a register.
- I_WB_ADDR  input  P_ADDR_WIDTH  destination register.
- I_FLAGS_EN  input  1  instruction updates the PSR.
- I_FLUSH  input  1  synchronous drop of all buffered entries.
- O_VALID  output  1  head entry valid.
- I_READY  input  1  register file consumes head.
- O_DATA  output  P_WIDTH  head result.
- O_WB_EN  output  1  head write enable; gated by O_VALID.
- O_WB_ADDR  output  P_ADDR_WIDTH  head destination.
- O_PSR  output  5  architectural flags, same bit order as I_STATUS.
- I_COND  input  4  condition code to evaluate.
- O_COND_TRUE  output  1  condition result (combinational from PSR).

Behaviour:
- Reset (I_NRESET low, async): count = 0, O_VALID = 0, O_DATA = 0, O_WB_EN = 0, O_WB_ADDR = 0, O_PSR = 0. O_READY = 1 once out of reset.
- Accept = I_VALID & O_READY. Pop = O_VALID & I_READY.
- Buffer: two-entry FIFO (head, tail). State EMPTY / ONE / FULL, encoded as count 0/1/2.
  - EMPTY: accept -> ONE; the entry is visible at O_VALID next cycle (latency 1).
  - ONE: accept & pop -> ONE (new entry becomes head); accept only -> FULL; pop only -> EMPTY.
  - FULL: O_READY = 0; pop -> ONE (tail moves to head).
- Outputs are registered. No combinational path from I_VALID to O_VALID, or from I_READY to O_READY.
- Ordering is strict FIFO. No entry is ever dropped or duplicated except by flush.
- PSR:
  - On accept with I_FLAGS_EN = 1, PSR <= I_STATUS at the same edge, independent of buffer drain.
  - Accept with I_FLAGS_EN = 0 leaves PSR unchanged.
- I_FLUSH = 1:
  - count <= 0, O_VALID <= 0.
  - A coincident accept is discarded; its flags are NOT written to PSR.
  - PSR otherwise retained.
  - O_READY does not depend on I_FLUSH.
- Condition codes (I_COND -> true when):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 10 LO: !L & !Z
  - 11 HS: L | Z
  - 12 LT: !N & !Z
  - 13 GE: N | Z
  - 14 UC: 1
  - 15: 0
- Reset asserted mid-transfer: buffered entries are lost and PSR = 0 immediately.

Optional Feature:
- Macro ALU_WB_PSR_BYPASS_EN.
- Defined: O_COND_TRUE is evaluated on the bypassed status whenever a non-flushed accept with I_FLAGS_EN = 1 occurs in the same cycle. Bypassed status = I_STATUS in that case, else O_PSR. This gives a zero-bubble compare-then-branch. O_PSR itself stays registered.
- Undefined: O_COND_TRUE is evaluated on O_PSR only, i.e. one cycle after the flag-setting accept.

Decomposition:
- Shared package cr16_pkg holds:
  - status bit index constants (C = 0, L = 1, F = 2, Z = 3, N = 4);
  - the 4-bit condition-code localparams (EQ … UC, NEVER);
  - PSR width = 5.
- One sub-module, cond_eval: purely combinational (psr, cond) -> true. It is reused by the branch unit.

Test Plan:
- Reset, then single accept (I_C = 16'h1234, I_WB_ADDR = 3, I_WB_EN = 1) -> O_VALID = 1 the next cycle, O_DATA = 16'h1234, O_WB_ADDR = 3; after pop, O_VALID = 0.
- I_READY held 0, three consecutive I_VALID (16'h0001/0002/0003) -> O_READY drops to 0 after the second accept; the third is held upstream; releasing I_READY yields 0001, 0002, 0003 in order.
- Accept with I_FLAGS_EN = 1, I_STATUS = 5'b01000 -> O_PSR = 5'b01000 next cycle. Then I_COND = 0 (EQ) -> 1, and I_COND = 1 (NE) -> 0. With the macro defined, EQ reads 1 in the accept cycle itself.
- Accept with I_FLAGS_EN = 0, I_STATUS = 5'b11111 -> O_PSR is unchanged; I_COND = 14 -> 1 and I_COND = 15 -> 0 regardless of PSR.
- FULL buffer, then I_FLUSH = 1 together with I_VALID and I_FLAGS_EN = 1, I_STATUS = 5'b00001 -> O_VALID = 0 next cycle, O_PSR is unchanged, and the flushed-cycle data never appears.
- I_NRESET pulsed low asynchronously mid-cycle while FULL -> O_VALID = 0 and O_PSR = 0 immediately, without waiting for a clock edge.
